// File: rtl/sdram_master_arbiter_if.sv
// Signal bundle between the vertex-fetch, depth-fetch and z-write requesters,
// the shared Avalon-MM SDRAM master port and the arbiter joining them.
interface sdram_master_arbiter_if;
  logic [25:0] s0_address;
  logic        s0_read;
  logic        s0_write;
  logic [3:0]  s0_byteenable;
  logic [31:0] s0_writedata;
  logic        s0_waitrequest;
  logic [31:0] s0_readdata;
  logic        s0_readdatavalid;

  logic [25:0] s1_address;
  logic        s1_read;
  logic        s1_write;
  logic [3:0]  s1_byteenable;
  logic [31:0] s1_writedata;
  logic        s1_waitrequest;
  logic [31:0] s1_readdata;
  logic        s1_readdatavalid;

  logic [25:0] s2_address;
  logic        s2_read;
  logic        s2_write;
  logic [3:0]  s2_byteenable;
  logic [31:0] s2_writedata;
  logic        s2_waitrequest;
  logic [31:0] s2_readdata;
  logic        s2_readdatavalid;

  logic [25:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_waitrequest;

  logic [4:0]  pending_count;
  logic        resp_error;

  // Arbiter side: takes requests and downstream responses, drives the rest.
  modport slave (
    input  s0_address, s0_read, s0_write, s0_byteenable, s0_writedata,
    input  s1_address, s1_read, s1_write, s1_byteenable, s1_writedata,
    input  s2_address, s2_read, s2_write, s2_byteenable, s2_writedata,
    input  master_readdata, master_readdatavalid, master_waitrequest,
    output s0_waitrequest, s0_readdata, s0_readdatavalid,
    output s1_waitrequest, s1_readdata, s1_readdatavalid,
    output s2_waitrequest, s2_readdata, s2_readdatavalid,
    output master_address, master_read, master_write, master_byteenable, master_writedata,
    output pending_count, resp_error
  );

  // Environment side: requesters plus the SDRAM controller.
  modport master (
    output s0_address, s0_read, s0_write, s0_byteenable, s0_writedata,
    output s1_address, s1_read, s1_write, s1_byteenable, s1_writedata,
    output s2_address, s2_read, s2_write, s2_byteenable, s2_writedata,
    output master_readdata, master_readdatavalid, master_waitrequest,
    input  s0_waitrequest, s0_readdata, s0_readdatavalid,
    input  s1_waitrequest, s1_readdata, s1_readdatavalid,
    input  s2_waitrequest, s2_readdata, s2_readdatavalid,
    input  master_address, master_read, master_write, master_byteenable, master_writedata,
    input  pending_count, resp_error
  );
endinterface

// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master among three requesters,
// with an ID FIFO that steers each pipelined read response back to its issuer.
module sdram_master_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int MAX_PENDING = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_master_arbiter_if.slave bus
);
  localparam int         PTR_W    = $clog2(MAX_PENDING);
  localparam logic [1:0] LAST_RST = 2'(NUM_REQ - 1);
  localparam logic [4:0] FULL_CNT = 5'(MAX_PENDING);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  state_e      state_r, state_n_s;
  logic [1:0]  grant_id_r, grant_id_n_s;
  logic [1:0]  last_id_r, last_id_n_s;

  logic [3:0]  req_s;
  logic        granted_s;
  logic        full_s;
  logic        accept_s;
  logic        req_g_s;

  logic [25:0] g_address_s;
  logic        g_read_s;
  logic        g_write_s;
  logic [3:0]  g_byteenable_s;
  logic [31:0] g_writedata_s;

  logic [1:0]  base_s, cand1_s, cand2_s, cand3_s, pick_s;
  logic        found_s;

  logic [1:0]       id_mem_r [MAX_PENDING];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [4:0]       pending_count_r;
  logic             resp_error_r;
  logic             push_s, pop_s, orphan_s;
  logic [1:0]       head_id_s;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    next_id = (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Bit 3 pads the vector so any 2-bit index is in range.
  assign req_s = {1'b0,
                  bus.s2_read | bus.s2_write,
                  bus.s1_read | bus.s1_write,
                  bus.s0_read | bus.s0_write};

  assign granted_s = (state_r == ST_GRANTED);
  assign full_s    = (pending_count_r == FULL_CNT);
  assign req_g_s   = g_read_s | g_write_s;
  assign accept_s  = granted_s & req_g_s & ~bus.master_waitrequest & ~(g_read_s & full_s);

  // Select the command fields of the currently granted requester.
  always_comb begin
    g_address_s    = 26'd0;
    g_read_s       = 1'b0;
    g_write_s      = 1'b0;
    g_byteenable_s = 4'd0;
    g_writedata_s  = 32'd0;
    case (grant_id_r)
      2'd0: begin
        g_address_s    = bus.s0_address;
        g_read_s       = bus.s0_read;
        g_write_s      = bus.s0_write;
        g_byteenable_s = bus.s0_byteenable;
        g_writedata_s  = bus.s0_writedata;
      end
      2'd1: begin
        g_address_s    = bus.s1_address;
        g_read_s       = bus.s1_read;
        g_write_s      = bus.s1_write;
        g_byteenable_s = bus.s1_byteenable;
        g_writedata_s  = bus.s1_writedata;
      end
      2'd2: begin
        g_address_s    = bus.s2_address;
        g_read_s       = bus.s2_read;
        g_write_s      = bus.s2_write;
        g_byteenable_s = bus.s2_byteenable;
        g_writedata_s  = bus.s2_writedata;
      end
      default: begin
        g_address_s    = 26'd0;
        g_read_s       = 1'b0;
        g_write_s      = 1'b0;
        g_byteenable_s = 4'd0;
        g_writedata_s  = 32'd0;
      end
    endcase
  end

  // Rotating search; on an accept the rotation starts after the requester just served.
  always_comb begin
    base_s  = accept_s ? grant_id_r : last_id_r;
    cand1_s = next_id(base_s);
    cand2_s = next_id(cand1_s);
    cand3_s = next_id(cand2_s);
    found_s = 1'b1;
    pick_s  = cand1_s;
    if (req_s[cand1_s]) begin
      pick_s = cand1_s;
    end else if (req_s[cand2_s]) begin
      pick_s = cand2_s;
    end else if (req_s[cand3_s]) begin
      pick_s = cand3_s;
    end else begin
      found_s = 1'b0;
      pick_s  = base_s;
    end
  end

  // Next-state logic for the grant FSM.
  always_comb begin
    state_n_s    = state_r;
    grant_id_n_s = grant_id_r;
    last_id_n_s  = last_id_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_n_s    = ST_GRANTED;
          grant_id_n_s = pick_s;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (accept_s) begin
          last_id_n_s  = grant_id_r;
          state_n_s    = found_s ? ST_GRANTED : ST_IDLE;
          grant_id_n_s = pick_s;
        end else if (!req_g_s) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_GRANTED;
        end
      end
      default: begin
        state_n_s    = ST_IDLE;
        grant_id_n_s = 2'd0;
        last_id_n_s  = LAST_RST;
      end
    endcase
  end

  // Grant FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_id_r <= 2'd0;
      last_id_r  <= LAST_RST;
    end else begin
      state_r    <= state_n_s;
      grant_id_r <= grant_id_n_s;
      last_id_r  <= last_id_n_s;
    end
  end

  // Downstream command mux; a read-and-write request is issued as a read only.
  always_comb begin
    if (granted_s) begin
      bus.master_address    = g_address_s;
      bus.master_read       = g_read_s & ~full_s;
      bus.master_write      = g_write_s & ~g_read_s;
      bus.master_byteenable = g_byteenable_s;
      bus.master_writedata  = g_writedata_s;
    end else begin
      bus.master_address    = 26'd0;
      bus.master_read       = 1'b0;
      bus.master_write      = 1'b0;
      bus.master_byteenable = 4'd0;
      bus.master_writedata  = 32'd0;
    end
  end

  assign bus.s0_waitrequest = ~(accept_s & (grant_id_r == 2'd0));
  assign bus.s1_waitrequest = ~(accept_s & (grant_id_r == 2'd1));
  assign bus.s2_waitrequest = ~(accept_s & (grant_id_r == 2'd2));

  assign push_s    = accept_s & g_read_s;
  assign pop_s     = bus.master_readdatavalid & (pending_count_r != 5'd0);
  assign orphan_s  = bus.master_readdatavalid & (pending_count_r == 5'd0);
  assign head_id_s = id_mem_r[rd_ptr_r];

  // Outstanding-read ID FIFO with occupancy count and sticky orphan-response flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_PENDING; i++) begin
        id_mem_r[i] <= 2'd0;
      end
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      pending_count_r <= 5'd0;
      resp_error_r    <= 1'b0;
    end else begin
      if (push_s) begin
        id_mem_r[wr_ptr_r] <= grant_id_r;
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   pending_count_r <= pending_count_r + 5'd1;
        2'b01:   pending_count_r <= pending_count_r - 5'd1;
        default: pending_count_r <= pending_count_r;
      endcase
      if (orphan_s) begin
        resp_error_r <= 1'b1;
      end
    end
  end

  // Read data is broadcast; only the valid strobe follows the FIFO head.
  assign bus.s0_readdata      = bus.master_readdata;
  assign bus.s1_readdata      = bus.master_readdata;
  assign bus.s2_readdata      = bus.master_readdata;
  assign bus.s0_readdatavalid = pop_s & (head_id_s == 2'd0);
  assign bus.s1_readdatavalid = pop_s & (head_id_s == 2'd1);
  assign bus.s2_readdatavalid = pop_s & (head_id_s == 2'd2);

  assign bus.pending_count = pending_count_r;
  assign bus.resp_error    = resp_error_r;
endmodule
